// File: rtl/opfetch_pkg.sv
// -----------------------------------------------------------------------------
// opfetch_pkg
// Shared definitions for the decode/operand-fetch stage: MIPS opcode and funct
// constants, the immediate-extension kind enum, the decode result struct and a
// helper that builds the 32-bit immediate from the low 26 instruction bits.
// No ports (package). Configuration macro used by the stage: OPFETCH_BYPASS_EN.
// -----------------------------------------------------------------------------
package opfetch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    IMM_SIGN,
    IMM_ZERO,
    IMM_UPPER,
    IMM_JUMP
  } imm_kind_e;

  typedef struct packed {
    logic       src1_en;
    logic       src2_en;
    logic [4:0] dest;
    logic       dest_en;
    imm_kind_e  imm_kind;
  } decode_t;

  // Builds the extended immediate; field is Instr[25:0] so jump targets and
  // 16-bit immediates come from the same slice.
  function automatic logic [31:0] extendImm(input imm_kind_e kind, input logic [25:0] field);
    logic [31:0] result;
    case (kind)
      IMM_ZERO:  result = {16'h0000, field[15:0]};
      IMM_UPPER: result = {field[15:0], 16'h0000};
      IMM_JUMP:  result = {6'h00, field};
      default:   result = {{16{field[15]}}, field[15:0]};
    endcase
    return result;
  endfunction

endpackage

// File: rtl/opfetch_decode.sv
// -----------------------------------------------------------------------------
// opfetch_decode
// Purely combinational MIPS decoder: classifies which register fields are read,
// which register (if any) is written, and produces the extended immediate.
// Ports:
//   instr_i  in  32  instruction word
//   dec_o    out     decode struct (source enables, destination, imm kind)
//   imm_o    out 32  extended immediate
// -----------------------------------------------------------------------------
module opfetch_decode
  import opfetch_pkg::*;
(
  input  logic [31:0] instr_i,
  output decode_t     dec_o,
  output logic [31:0] imm_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rtField;
  logic [4:0] rdField;

  assign opcode  = instr_i[31:26];
  assign funct   = instr_i[5:0];
  assign rtField = instr_i[20:16];
  assign rdField = instr_i[15:11];

  // Opcode classification. Anything unrecognised is treated conservatively as
  // reading both rs and rt and writing nothing, so it can never race a write.
  // When an instruction has no destination the dest field is forced to zero
  // so OutDest never carries stale register-field bits.
  always_comb begin
    dec_o = '{src1_en: 1'b1, src2_en: 1'b1, dest: REG_ZERO, dest_en: 1'b0, imm_kind: IMM_SIGN};
    case (opcode)
      OP_RTYPE: begin
        if (funct != FUNCT_JR) begin
          dec_o.dest_en = 1'b1;
          dec_o.dest    = rdField;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: begin
        dec_o.src2_en = 1'b0;
        dec_o.dest_en = 1'b1;
        dec_o.dest    = rtField;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_o.src2_en  = 1'b0;
        dec_o.dest_en  = 1'b1;
        dec_o.dest     = rtField;
        dec_o.imm_kind = IMM_ZERO;
      end
      OP_LUI: begin
        dec_o.src1_en  = 1'b0;
        dec_o.src2_en  = 1'b0;
        dec_o.dest_en  = 1'b1;
        dec_o.dest     = rtField;
        dec_o.imm_kind = IMM_UPPER;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        dec_o.imm_kind = IMM_SIGN;
      end
      OP_J: begin
        dec_o.src1_en  = 1'b0;
        dec_o.src2_en  = 1'b0;
        dec_o.imm_kind = IMM_JUMP;
      end
      OP_JAL: begin
        dec_o.src1_en  = 1'b0;
        dec_o.src2_en  = 1'b0;
        dec_o.dest_en  = 1'b1;
        dec_o.dest     = REG_RA;
        dec_o.imm_kind = IMM_JUMP;
      end
      default: begin
        dec_o.imm_kind = IMM_SIGN;
      end
    endcase
  end

  assign imm_o = extendImm(dec_o.imm_kind, instr_i[25:0]);

endmodule

// File: rtl/regfile_operand_fetch.sv
// -----------------------------------------------------------------------------
// regfile_operand_fetch
// Decode/operand-read stage in front of the register file. Accepts one MIPS
// instruction per cycle over valid/ready, reads rs/rt from the regfile, and
// captures operands, immediate and destination into an output register. A
// per-register pending scoreboard stalls issue on RAW/WAW hazards against
// writes that have not yet reached writeback.
// Optional feature macro: OPFETCH_BYPASS_EN (writeback forwarding into the
// hazard check and operand muxes; default build has no forwarding).
// Ports:
//   Clk, Reset_n                 clock, async active-low reset
//   InstrValid/InstrReady/Instr  instruction handshake
//   ReadRegister1/2, ReadData1/2 regfile read ports (combinational)
//   WbRegWrite/WbWriteRegister/WbWriteData  writeback commit
//   OutValid/OutReady            output handshake
//   OutOpA/OutOpB/OutImm/OutDest/OutDestEn/OutOpcode/OutFunct  output fields
// -----------------------------------------------------------------------------
module regfile_operand_fetch
  import opfetch_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [31:0] Instr,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        WbRegWrite,
  input  logic [4:0]  WbWriteRegister,
  input  logic [31:0] WbWriteData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutOpA,
  output logic [31:0] OutOpB,
  output logic [31:0] OutImm,
  output logic [4:0]  OutDest,
  output logic        OutDestEn,
  output logic [5:0]  OutOpcode,
  output logic [5:0]  OutFunct
);

`ifdef OPFETCH_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  decode_t     dec;
  logic [31:0] decImm;
  logic [4:0]  rsIdx;
  logic [4:0]  rtIdx;

  logic             wbActive;
  logic [NREGS-1:0] wbClear;
  logic [NREGS-1:0] effPending;
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  logic srcHazard1;
  logic srcHazard2;
  logic destHazard;
  logic hazard;
  logic issue;

  logic [31:0] opA;
  logic [31:0] opB;

  logic        outValid_q;
  logic [31:0] outOpA_q;
  logic [31:0] outOpB_q;
  logic [31:0] outImm_q;
  logic [4:0]  outDest_q;
  logic        outDestEn_q;
  logic [5:0]  outOpcode_q;
  logic [5:0]  outFunct_q;

  opfetch_decode uDecode (
    .instr_i (Instr),
    .dec_o   (dec),
    .imm_o   (decImm)
  );

  assign rsIdx         = Instr[25:21];
  assign rtIdx         = Instr[20:16];
  assign ReadRegister1 = rsIdx;
  assign ReadRegister2 = rtIdx;

  // Writes to r0 are architecturally discarded, so they neither clear nor
  // forward anything.
  assign wbActive = WbRegWrite && (WbWriteRegister != REG_ZERO);

  // One-hot of the register being committed this cycle.
  always_comb begin
    wbClear = '0;
    if (wbActive) begin
      wbClear[WbWriteRegister] = 1'b1;
    end
  end

  // With forwarding the committing register already counts as resolved for
  // hazard purposes; without it the scoreboard bit is the whole story.
  assign effPending = BypassEn ? (pending_q & ~wbClear) : pending_q;

  // Hazard detection. r0 is never a hazard. Without forwarding a source that
  // matches the in-progress writeback must also wait, because the regfile read
  // this cycle still returns the old value.
  always_comb begin
    srcHazard1 = 1'b0;
    srcHazard2 = 1'b0;
    destHazard = 1'b0;
    if (dec.src1_en && (rsIdx != REG_ZERO)) begin
      srcHazard1 = effPending[rsIdx] || (!BypassEn && wbActive && (WbWriteRegister == rsIdx));
    end
    if (dec.src2_en && (rtIdx != REG_ZERO)) begin
      srcHazard2 = effPending[rtIdx] || (!BypassEn && wbActive && (WbWriteRegister == rtIdx));
    end
    if (dec.dest_en && (dec.dest != REG_ZERO)) begin
      destHazard = effPending[dec.dest];
    end
    hazard = srcHazard1 || srcHazard2 || destHazard;
  end

  assign InstrReady = !hazard && (!outValid_q || OutReady);
  assign issue      = InstrValid && InstrReady;

  // Operand selection: r0 reads as zero regardless of the regfile; with
  // forwarding a source matching the committing register takes the WB data.
  always_comb begin
    opA = ReadData1;
    if (rsIdx == REG_ZERO) begin
      opA = '0;
    end else if (BypassEn && wbActive && (WbWriteRegister == rsIdx)) begin
      opA = WbWriteData;
    end
    opB = ReadData2;
    if (rtIdx == REG_ZERO) begin
      opB = '0;
    end else if (BypassEn && wbActive && (WbWriteRegister == rtIdx)) begin
      opB = WbWriteData;
    end
  end

  // Scoreboard next state. The set is applied after the clear so that a new
  // writer issued in the same cycle as the previous writer's commit keeps the
  // register pending.
  always_comb begin
    pending_d = pending_q;
    if (wbActive) begin
      pending_d[WbWriteRegister] = 1'b0;
    end
    if (issue && dec.dest_en && (dec.dest != REG_ZERO)) begin
      pending_d[dec.dest] = 1'b1;
    end
  end

  // Scoreboard register; reset throws away any in-flight writes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Output pipeline register. Fields only load on issue, so they stay stable
  // for as long as downstream back-pressures; valid drops once consumed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      outValid_q  <= 1'b0;
      outOpA_q    <= '0;
      outOpB_q    <= '0;
      outImm_q    <= '0;
      outDest_q   <= '0;
      outDestEn_q <= 1'b0;
      outOpcode_q <= '0;
      outFunct_q  <= '0;
    end else if (issue) begin
      outValid_q  <= 1'b1;
      outOpA_q    <= opA;
      outOpB_q    <= opB;
      outImm_q    <= decImm;
      outDest_q   <= dec.dest;
      outDestEn_q <= dec.dest_en;
      outOpcode_q <= Instr[31:26];
      outFunct_q  <= Instr[5:0];
    end else if (OutReady) begin
      outValid_q  <= 1'b0;
    end
  end

  assign OutValid  = outValid_q;
  assign OutOpA    = outOpA_q;
  assign OutOpB    = outOpB_q;
  assign OutImm    = outImm_q;
  assign OutDest   = outDest_q;
  assign OutDestEn = outDestEn_q;
  assign OutOpcode = outOpcode_q;
  assign OutFunct  = outFunct_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_regfile_operand_fetch
// Self-checking bench for regfile_operand_fetch. Contains a small register
// file, a behavioural reference model of the stage (decode tables, pending set
// and output register expressed directly from the MIPS operand rules), a set
// of directed scenarios and a randomized run. Honours OPFETCH_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk;
  logic        Reset_n;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        WbRegWrite;
  logic [4:0]  WbWriteRegister;
  logic [31:0] WbWriteData;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutOpA;
  logic [31:0] OutOpB;
  logic [31:0] OutImm;
  logic [4:0]  OutDest;
  logic        OutDestEn;
  logic [5:0]  OutOpcode;
  logic [5:0]  OutFunct;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];

  bit [31:0]   mPend;
  bit          mValid;
  logic [31:0] mOpA;
  logic [31:0] mOpB;
  logic [31:0] mImm;
  logic [4:0]  mDest;
  logic        mDestEn;
  logic [5:0]  mOpc;
  logic [5:0]  mFun;

  regfile_operand_fetch #(.NREGS(32)) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .InstrValid      (InstrValid),
    .InstrReady      (InstrReady),
    .Instr           (Instr),
    .ReadRegister1   (ReadRegister1),
    .ReadRegister2   (ReadRegister2),
    .ReadData1       (ReadData1),
    .ReadData2       (ReadData2),
    .WbRegWrite      (WbRegWrite),
    .WbWriteRegister (WbWriteRegister),
    .WbWriteData     (WbWriteData),
    .OutValid        (OutValid),
    .OutReady        (OutReady),
    .OutOpA          (OutOpA),
    .OutOpB          (OutOpB),
    .OutImm          (OutImm),
    .OutDest         (OutDest),
    .OutDestEn       (OutDestEn),
    .OutOpcode       (OutOpcode),
    .OutFunct        (OutFunct)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file the stage reads from: combinational read, write at the edge.
  assign ReadData1 = rf[ReadRegister1];
  assign ReadData2 = rf[ReadRegister2];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (WbRegWrite && (WbWriteRegister != 5'd0)) begin
      rf[WbWriteRegister] <= WbWriteData;
    end
  end

  // MIPS operand-usage tables.
  function automatic bit usesRs(input logic [31:0] ins);
    case (ins[31:26])
      6'h0F, 6'h02, 6'h03: return 1'b0;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic bit usesRt(input logic [31:0] ins);
    case (ins[31:26])
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h0F, 6'h02, 6'h03: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit destEnOf(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: return ins[5:0] != 6'h08;
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h0F, 6'h03: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] destOf(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:   return ins[15:11];
      6'h03:   return 5'd31;
      default: return ins[20:16];
    endcase
  endfunction

  function automatic logic [31:0] immOf(input logic [31:0] ins);
    logic signed [15:0] s;
    s = ins[15:0];
    case (ins[31:26])
      6'h0C, 6'h0D, 6'h0E: return {16'h0000, ins[15:0]};
      6'h0F:               return {ins[15:0], 16'h0000};
      6'h02, 6'h03:        return {6'h00, ins[25:0]};
      default:             return 32'(s);
    endcase
  endfunction

  function automatic bit wbHit(input logic [4:0] idx);
    return WbRegWrite && (WbWriteRegister == idx) && (idx != 5'd0);
  endfunction

  function automatic bit effPend(input logic [4:0] idx);
    return (idx != 5'd0) && mPend[idx] && !(BYP && wbHit(idx));
  endfunction

  function automatic bit busySrc(input logic [4:0] idx);
    return (idx != 5'd0) && (effPend(idx) || (!BYP && wbHit(idx)));
  endfunction

  function automatic bit mReady();
    bit haz;
    haz = 1'b0;
    if (usesRs(Instr) && busySrc(Instr[25:21])) haz = 1'b1;
    if (usesRt(Instr) && busySrc(Instr[20:16])) haz = 1'b1;
    if (destEnOf(Instr) && (destOf(Instr) != 5'd0) && effPend(destOf(Instr))) haz = 1'b1;
    return !haz && (!mValid || OutReady);
  endfunction

  function automatic logic [31:0] opVal(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (BYP && wbHit(idx)) return WbWriteData;
    return rf[idx];
  endfunction

  function automatic bit [31:0] nextPend(input bit iss);
    bit [31:0] p;
    p = mPend;
    if (WbRegWrite && (WbWriteRegister != 5'd0)) p[WbWriteRegister] = 1'b0;
    if (iss && destEnOf(Instr) && (destOf(Instr) != 5'd0)) p[destOf(Instr)] = 1'b1;
    return p;
  endfunction

  // Reference model of the stage, advanced from the inputs seen at each edge.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mPend   <= '0;
      mValid  <= 1'b0;
      mOpA    <= '0;
      mOpB    <= '0;
      mImm    <= '0;
      mDest   <= '0;
      mDestEn <= 1'b0;
      mOpc    <= '0;
      mFun    <= '0;
    end else begin
      mPend <= nextPend(InstrValid && mReady());
      if (InstrValid && mReady()) begin
        mValid  <= 1'b1;
        mOpA    <= opVal(Instr[25:21]);
        mOpB    <= opVal(Instr[20:16]);
        mImm    <= immOf(Instr);
        mDest   <= destOf(Instr);
        mDestEn <= destEnOf(Instr);
        mOpc    <= Instr[31:26];
        mFun    <= Instr[5:0];
      end else if (OutReady) begin
        mValid <= 1'b0;
      end
    end
  end

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy);
    InstrValid = v;
    Instr      = ins;
    OutReady   = rdy;
  endtask

  task automatic setWb(input logic en, input logic [4:0] r, input logic [31:0] d);
    WbRegWrite      = en;
    WbWriteRegister = r;
    WbWriteData     = d;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'd0, 1'b1);
    setWb(1'b0, 5'd0, 32'd0);
    Reset_n = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic wbWrite(input logic [4:0] r, input logic [31:0] d);
    setWb(1'b1, r, d);
    tick();
    setWb(1'b0, 5'd0, 32'd0);
  endtask

  // Reset state, async mid-operation reset, and discarded pending state.
  task automatic test_reset();
    doReset();
    applyStimulus(1'b1, 32'h2043FFFF, 1'b1);
    #1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", OutValid); end
    total++; if (OutOpA !== 32'd0) begin bad++; $display("[TB] FAIL rst_opa: got %h want 0", OutOpA); end
    total++; if (OutImm !== 32'd0) begin bad++; $display("[TB] FAIL rst_imm: got %h want 0", OutImm); end
    total++; if (InstrReady !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %b want 1", InstrReady); end
    tick();
    total++; if (OutValid !== 1'b1) begin bad++; $display("[TB] FAIL pre_midrst_valid: got %b want 1", OutValid); end
    InstrValid = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    total++; if (OutValid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %b want 0", OutValid); end
    total++; if (OutOpA !== 32'd0 || OutImm !== 32'd0) begin bad++; $display("[TB] FAIL midrst_data: got %h/%h want 0/0", OutOpA, OutImm); end
    total++; if (OutDest !== 5'd0 || OutDestEn !== 1'b0) begin bad++; $display("[TB] FAIL midrst_dest: got %0d/%b want 0/0", OutDest, OutDestEn); end
    #1;
    Reset_n = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h00632020, 1'b1);
    #1;
    total++; if (InstrReady !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pending_cleared: got %b want 1", InstrReady); end
    tick();
    InstrValid = 1'b0;
    total++; if (OutValid !== 1'b1 || OutDest !== 5'd4) begin bad++; $display("[TB] FAIL midrst_reissue: got %b/%0d want 1/4", OutValid, OutDest); end
  endtask

  // addi r3,r2,-1 with r2 = 42.
  task automatic test_addi();
    doReset();
    wbWrite(5'd2, 32'd42);
    applyStimulus(1'b1, 32'h2043FFFF, 1'b1);
    #1;
    total++; if (InstrReady !== 1'b1) begin bad++; $display("[TB] FAIL addi_ready: got %b want 1", InstrReady); end
    total++; if (ReadRegister1 !== 5'd2 || ReadRegister2 !== 5'd3) begin bad++; $display("[TB] FAIL addi_readreg: got %0d/%0d want 2/3", ReadRegister1, ReadRegister2); end
    tick();
    InstrValid = 1'b0;
    total++; if (OutOpA !== 32'd42) begin bad++; $display("[TB] FAIL addi_opa: got %0d want 42", OutOpA); end
    total++; if (OutImm !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL addi_imm: got %h want ffffffff", OutImm); end
    total++; if (OutDest !== 5'd3 || OutDestEn !== 1'b1) begin bad++; $display("[TB] FAIL addi_dest: got %0d/%b want 3/1", OutDest, OutDestEn); end
    total++; if (OutOpcode !== 6'h08 || OutValid !== 1'b1) begin bad++; $display("[TB] FAIL addi_opcode: got %h/%b want 08/1", OutOpcode, OutValid); end
  endtask

  // addi r3 then dependent add r4,r3,r3, resolved by WB r3 = 7.
  task automatic test_raw();
    doReset();
    applyStimulus(1'b1, 32'h20430001, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h00632020, 1'b1);
    #1;
    total++; if (InstrReady !== 1'b0) begin bad++; $display("[TB] FAIL raw_stall0: got %b want 0", InstrReady); end
    tick();
    total++; if (InstrReady !== 1'b0) begin bad++; $display("[TB] FAIL raw_stall1: got %b want 0", InstrReady); end
    setWb(1'b1, 5'd3, 32'd7);
    #1;
`ifdef OPFETCH_BYPASS_EN
    total++; if (InstrReady !== 1'b1) begin bad++; $display("[TB] FAIL raw_bypass_ready: got %b want 1", InstrReady); end
    tick();
    setWb(1'b0, 5'd0, 32'd0);
`else
    total++; if (InstrReady !== 1'b0) begin bad++; $display("[TB] FAIL raw_wbcycle_ready: got %b want 0", InstrReady); end
    tick();
    setWb(1'b0, 5'd0, 32'd0);
    #1;
    total++; if (InstrReady !== 1'b1) begin bad++; $display("[TB] FAIL raw_after_wb_ready: got %b want 1", InstrReady); end
    tick();
`endif
    InstrValid = 1'b0;
    total++; if (OutOpA !== 32'd7 || OutOpB !== 32'd7) begin bad++; $display("[TB] FAIL raw_operands: got %0d/%0d want 7/7", OutOpA, OutOpB); end
    total++; if (OutValid !== 1'b1 || OutDest !== 5'd4) begin bad++; $display("[TB] FAIL raw_dest: got %b/%0d want 1/4", OutValid, OutDest); end
  endtask

  // Zero-extended ori, lui upper immediate; r0 writes never block.
  task automatic test_imm();
    doReset();
    applyStimulus(1'b1, 32'h20000001, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h34058000, 1'b1);
    #1;
    total++; if (InstrReady !== 1'b1) begin bad++; $display("[TB] FAIL ori_ready: got %b want 1", InstrReady); end
    tick();
    total++; if (OutImm !== 32'h00008000) begin bad++; $display("[TB] FAIL ori_imm: got %h want 00008000", OutImm); end
    total++; if (OutDest !== 5'd5 || OutOpA !== 32'd0) begin bad++; $display("[TB] FAIL ori_dest: got %0d/%h want 5/0", OutDest, OutOpA); end
    applyStimulus(1'b1, 32'h3C061234, 1'b1);
    #1;
    total++; if (InstrReady !== 1'b1) begin bad++; $display("[TB] FAIL lui_ready: got %b want 1", InstrReady); end
    tick();
    InstrValid = 1'b0;
    total++; if (OutImm !== 32'h12340000) begin bad++; $display("[TB] FAIL lui_imm: got %h want 12340000", OutImm); end
    total++; if (OutDest !== 5'd6) begin bad++; $display("[TB] FAIL lui_dest: got %0d want 6", OutDest); end
  endtask

  // Output held while downstream stalls; waiting instruction accepted later.
  task automatic test_backpressure();
    doReset();
    applyStimulus(1'b1, 32'h20010005, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h34020003, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (InstrReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready c%0d: got %b want 0", c, InstrReady); end
      tick();
      total++; if (OutValid !== 1'b1 || OutImm !== 32'd5 || OutDest !== 5'd1 || OutOpcode !== 6'h08) begin
        bad++; $display("[TB] FAIL bp_hold c%0d: got %b/%h/%0d/%h want 1/5/1/08", c, OutValid, OutImm, OutDest, OutOpcode);
      end
    end
    OutReady = 1'b1;
    #1;
    total++; if (InstrReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b want 1", InstrReady); end
    tick();
    InstrValid = 1'b0;
    total++; if (OutImm !== 32'd3 || OutDest !== 5'd2 || OutOpcode !== 6'h0D) begin bad++; $display("[TB] FAIL bp_second: got %h/%0d/%h want 3/2/0d", OutImm, OutDest, OutOpcode); end
    tick();
    total++; if (OutValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain: got %b want 0", OutValid); end
  endtask

  // WAW: lw r7 behind pending addi r7; r7 must remain pending afterwards.
  task automatic test_waw();
    doReset();
    applyStimulus(1'b1, 32'h20070005, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h8C270000, 1'b1);
    #1;
    total++; if (InstrReady !== 1'b0) begin bad++; $display("[TB] FAIL waw_stall: got %b want 0", InstrReady); end
    tick();
    setWb(1'b1, 5'd7, 32'd9);
    #1;
`ifdef OPFETCH_BYPASS_EN
    total++; if (InstrReady !== 1'b1) begin bad++; $display("[TB] FAIL waw_bypass_ready: got %b want 1", InstrReady); end
    tick();
    setWb(1'b0, 5'd0, 32'd0);
`else
    total++; if (InstrReady !== 1'b0) begin bad++; $display("[TB] FAIL waw_wbcycle_ready: got %b want 0", InstrReady); end
    tick();
    setWb(1'b0, 5'd0, 32'd0);
    tick();
`endif
    total++; if (OutOpcode !== 6'h23 || OutDest !== 5'd7) begin bad++; $display("[TB] FAIL waw_lw_out: got %h/%0d want 23/7", OutOpcode, OutDest); end
    applyStimulus(1'b1, 32'h00E04020, 1'b1);
    #1;
    total++; if (InstrReady !== 1'b0) begin bad++; $display("[TB] FAIL waw_still_pending: got %b want 0", InstrReady); end
    tick();
    InstrValid = 1'b0;
  endtask

  function automatic logic [31:0] randInstr();
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    case ($urandom_range(0, 15))
      0, 1:    op = 6'h00;
      2:       op = 6'h08;
      3:       op = 6'h09;
      4:       op = 6'h0A;
      5:       op = 6'h0C;
      6:       op = 6'h0D;
      7:       op = 6'h0E;
      8:       op = 6'h0F;
      9:       op = 6'h23;
      10:      op = 6'h2B;
      11:      op = 6'h04;
      12:      op = 6'h05;
      13:      op = 6'h02;
      14:      op = 6'h03;
      default: op = 6'h3F;
    endcase
    case ($urandom_range(0, 3))
      0:       fn = 6'h20;
      1:       fn = 6'h08;
      2:       fn = 6'h22;
      default: fn = 6'h2A;
    endcase
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    if (op == 6'h00) return {op, rs, rt, rd, 5'd0, fn};
    return {op, rs, rt, 16'($urandom)};
  endfunction

  function automatic logic [4:0] pickPending();
    int start;
    int r;
    start = $urandom_range(1, 31);
    for (int n = 0; n < 31; n++) begin
      r = ((start - 1 + n) % 31) + 1;
      if (mPend[r]) return 5'(r);
    end
    return 5'd0;
  endfunction

  // Randomized traffic against the reference model.
  task automatic test_random();
    logic [4:0] wr;
    doReset();
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 3) != 0), randInstr(), ($urandom_range(0, 3) != 0));
      wr = pickPending();
      if (wr != 5'd0 && $urandom_range(0, 2) == 0) setWb(1'b1, wr, $urandom);
      else if ($urandom_range(0, 7) == 0) setWb(1'b1, 5'($urandom_range(0, 7)), $urandom);
      else setWb(1'b0, 5'd0, 32'd0);
      #1;
      total++; if (InstrReady !== mReady()) begin bad++; $display("[TB] FAIL rnd_ready c%0d: got %b want %b instr %h", c, InstrReady, mReady(), Instr); end
      total++; if (ReadRegister1 !== Instr[25:21] || ReadRegister2 !== Instr[20:16]) begin
        bad++; $display("[TB] FAIL rnd_readreg c%0d: got %0d/%0d want %0d/%0d", c, ReadRegister1, ReadRegister2, Instr[25:21], Instr[20:16]);
      end
      tick();
      total++; if (OutValid !== mValid) begin bad++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", c, OutValid, mValid); end
      total++; if (OutOpA !== mOpA || OutOpB !== mOpB) begin bad++; $display("[TB] FAIL rnd_ops c%0d: got %h/%h want %h/%h", c, OutOpA, OutOpB, mOpA, mOpB); end
      total++; if (OutImm !== mImm) begin bad++; $display("[TB] FAIL rnd_imm c%0d: got %h want %h", c, OutImm, mImm); end
      total++; if (OutOpcode !== mOpc || OutFunct !== mFun || OutDestEn !== mDestEn) begin
        bad++; $display("[TB] FAIL rnd_fields c%0d: got %h/%h/%b want %h/%h/%b", c, OutOpcode, OutFunct, OutDestEn, mOpc, mFun, mDestEn);
      end
      if (mDestEn) begin
        total++; if (OutDest !== mDest) begin bad++; $display("[TB] FAIL rnd_dest c%0d: got %0d want %0d", c, OutDest, mDest); end
      end
    end
    applyStimulus(1'b0, 32'd0, 1'b1);
    setWb(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b1);
    setWb(1'b0, 5'd0, 32'd0);
    test_reset();
    test_addi();
    test_raw();
    test_imm();
    test_backpressure();
    test_waw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
